// File: rtl/datapath_sequencer.sv
// Command sequencer for the mini SRC DataPath: turns one MOV/ALU/LDI command
// into per-cycle bus-select, register-select and latch-enable controls.
module datapath_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [3:0]            alu_func,
    input  logic [SEL_WIDTH-1:0]  rd,
    input  logic [SEL_WIDTH-1:0]  rs,
    input  logic [SEL_WIDTH-1:0]  rt,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  stall,
    output logic [1:0]            bus_src_sel,
    output logic [SEL_WIDTH-1:0]  gp_register_select,
    output logic [NUM_REGS-1:0]   gp_enable,
    output logic                  y_enable,
    output logic                  z_enable,
    output logic [3:0]            alu_func_out,
    output logic [DATA_WIDTH-1:0] imm_out,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOV_T0 = 3'd1,
        S_ALU_T0 = 3'd2,
        S_ALU_T1 = 3'd3,
        S_ALU_T2 = 3'd4,
        S_LDI_T0 = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t                state_r, state_s;
    logic [1:0]            op_r, op_s;
    logic [3:0]            func_r, func_s;
    logic [SEL_WIDTH-1:0]  rd_r, rd_s, rs_r, rs_s, rt_r, rt_s;
    logic [DATA_WIDTH-1:0] imm_r, imm_s;
    logic                  hold_s;

    logic [1:0]            bus_src_sel_r, bus_src_sel_s;
    logic [SEL_WIDTH-1:0]  gp_sel_r, gp_sel_s;
    logic [NUM_REGS-1:0]   gp_enable_r, gp_enable_s;
    logic                  y_enable_r, y_enable_s, z_enable_r, z_enable_s;
    logic [3:0]            alu_func_out_r, alu_func_out_s;
    logic [DATA_WIDTH-1:0] imm_out_r, imm_out_s;
    logic                  busy_r, busy_s, done_r, done_s, illegal_r, illegal_s;

    // Next state, field capture, and next-cycle output decode
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        func_s  = func_r;
        rd_s    = rd_r;
        rs_s    = rs_r;
        rt_s    = rt_r;
        imm_s   = imm_r;
        hold_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    op_s   = op;
                    func_s = alu_func;
                    rd_s   = rd;
                    rs_s   = rs;
                    rt_s   = rt;
                    imm_s  = imm;
                    case (op)
                        2'b00:   state_s = S_MOV_T0;
                        2'b01:   state_s = S_ALU_T0;
                        2'b10:   state_s = S_LDI_T0;
                        default: state_s = S_DONE;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MOV_T0: begin hold_s = stall; state_s = stall ? S_MOV_T0 : S_DONE;   end
            S_ALU_T0: begin hold_s = stall; state_s = stall ? S_ALU_T0 : S_ALU_T1; end
            S_ALU_T1: begin hold_s = stall; state_s = stall ? S_ALU_T1 : S_ALU_T2; end
            S_ALU_T2: begin hold_s = stall; state_s = stall ? S_ALU_T2 : S_DONE;   end
            S_LDI_T0: begin hold_s = stall; state_s = stall ? S_LDI_T0 : S_DONE;   end
            S_DONE:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered;
        // a stalled T state keeps its selects but drops every write enable.
        bus_src_sel_s  = 2'b11;
        gp_sel_s       = '0;
        gp_enable_s    = '0;
        y_enable_s     = 1'b0;
        z_enable_s     = 1'b0;
        alu_func_out_s = 4'd0;
        imm_out_s      = '0;
        case (state_s)
            S_MOV_T0: begin
                bus_src_sel_s = 2'b00;
                gp_sel_s      = rs_s;
                gp_enable_s   = hold_s ? '0 : onehot(rd_s);
            end
            S_ALU_T0: begin
                bus_src_sel_s = 2'b00;
                gp_sel_s      = rs_s;
                y_enable_s    = ~hold_s;
            end
            S_ALU_T1: begin
                bus_src_sel_s  = 2'b00;
                gp_sel_s       = rt_s;
                alu_func_out_s = func_s;
                z_enable_s     = ~hold_s;
            end
            S_ALU_T2: begin
                bus_src_sel_s = 2'b01;
                gp_enable_s   = hold_s ? '0 : onehot(rd_s);
            end
            S_LDI_T0: begin
                bus_src_sel_s = 2'b10;
                imm_out_s     = imm_s;
                gp_enable_s   = hold_s ? '0 : onehot(rd_s);
            end
            default: bus_src_sel_s = 2'b11;
        endcase
        busy_s    = (state_s != S_IDLE);
        done_s    = (state_s == S_DONE);
        illegal_s = done_s && (op_s == 2'b11);
    end

    // State, captured command fields and registered control outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r        <= S_IDLE;
            op_r           <= 2'd0;
            func_r         <= 4'd0;
            rd_r           <= '0;
            rs_r           <= '0;
            rt_r           <= '0;
            imm_r          <= '0;
            bus_src_sel_r  <= 2'b11;
            gp_sel_r       <= '0;
            gp_enable_r    <= '0;
            y_enable_r     <= 1'b0;
            z_enable_r     <= 1'b0;
            alu_func_out_r <= 4'd0;
            imm_out_r      <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            illegal_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            op_r           <= op_s;
            func_r         <= func_s;
            rd_r           <= rd_s;
            rs_r           <= rs_s;
            rt_r           <= rt_s;
            imm_r          <= imm_s;
            bus_src_sel_r  <= bus_src_sel_s;
            gp_sel_r       <= gp_sel_s;
            gp_enable_r    <= gp_enable_s;
            y_enable_r     <= y_enable_s;
            z_enable_r     <= z_enable_s;
            alu_func_out_r <= alu_func_out_s;
            imm_out_r      <= imm_out_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            illegal_r      <= illegal_s;
        end
    end

    assign bus_src_sel        = bus_src_sel_r;
    assign gp_register_select = gp_sel_r;
    assign gp_enable          = gp_enable_r;
    assign y_enable           = y_enable_r;
    assign z_enable           = z_enable_r;
    assign alu_func_out       = alu_func_out_r;
    assign imm_out            = imm_out_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign illegal            = illegal_r;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a small DataPath model (register
// file, Y, Z, bus mux, ALU) driven by the sequencer's control outputs.
module tb_datapath_sequencer;

    logic        clock = 1'b0;
    logic        clear, start, stall;
    logic [1:0]  op;
    logic [3:0]  alu_func, rd, rs, rt;
    logic [31:0] imm;
    logic [1:0]  bus_src_sel;
    logic [3:0]  gp_register_select, alu_func_out;
    logic [15:0] gp_enable;
    logic        y_enable, z_enable, busy, done, illegal;
    logic [31:0] imm_out;

    datapath_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .alu_func(alu_func),
        .rd(rd), .rs(rs), .rt(rt), .imm(imm), .stall(stall),
        .bus_src_sel(bus_src_sel), .gp_register_select(gp_register_select),
        .gp_enable(gp_enable), .y_enable(y_enable), .z_enable(z_enable),
        .alu_func_out(alu_func_out), .imm_out(imm_out), .busy(busy),
        .done(done), .illegal(illegal)
    );

    always #5 clock = ~clock;

    logic [31:0] regs [16];
    logic [31:0] y_q, z_q, bus;

    function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a, b);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            default: return a & b;
        endcase
    endfunction

    always_comb begin
        case (bus_src_sel)
            2'b00:   bus = regs[gp_register_select];
            2'b01:   bus = z_q;
            2'b10:   bus = imm_out;
            default: bus = 32'd0;
        endcase
    end

    always @(posedge clock) begin
        if (y_enable) y_q <= bus;
        if (z_enable) z_q <= alu_model(alu_func_out, y_q, bus);
        for (int i = 0; i < 16; i++) if (gp_enable[i]) regs[i] <= bus;
    end

    int tests = 0;
    int fails = 0;
    int y_k, z_k, gp_k, done_k, z_cnt, z_stalled, done_cnt, ill_cnt, gp_cnt, viol;
    logic [31:0] gp_val, bus_at_gp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command; k counts cycles after the accepting edge.
    task automatic run_cmd(input logic [1:0] o, input logic [3:0] f, d, s, t,
                           input logic [31:0] im, input int st_k, input int st_n,
                           input bit extra_start);
        @(negedge clock);
        op = o; alu_func = f; rd = d; rs = s; rt = t; imm = im; start = 1'b1;
        @(posedge clock);
        y_k = -1; z_k = -1; gp_k = -1; done_k = -1;
        z_cnt = 0; z_stalled = 0; done_cnt = 0; ill_cnt = 0; gp_cnt = 0; viol = 0;
        gp_val = 32'd0; bus_at_gp = 32'd0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (y_enable && y_k < 0) y_k = k;
            if (z_enable) begin
                z_cnt++;
                if (z_k < 0) z_k = k;
                if (k > st_k && k <= st_k + st_n) z_stalled++;
            end
            if (gp_enable != 16'd0) begin
                gp_cnt++;
                if (gp_k < 0) begin gp_k = k; gp_val = 32'(gp_enable); bus_at_gp = bus; end
            end
            if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
            if (illegal) ill_cnt++;
            if ((gp_enable != 16'd0 && (y_enable || z_enable)) || $countones(gp_enable) > 1) viol++;
            start = extra_start && (k == 1);
            op = 2'b00; alu_func = 4'd2; rd = 4'd15; rs = 4'd14; rt = 4'd13; imm = 32'hdead_beef;
            stall = (k >= st_k) && (k < st_k + st_n);
            if (done_k > 0 && k >= done_k + 3) break;
        end
        start = 1'b0; stall = 1'b0;
        check_eq("cmd_completed", 32'(done_k > 0), 32'd1);
    endtask

    task automatic read_reg(input logic [3:0] r);
        run_cmd(2'b00, 4'd0, 4'd0, r, 4'd0, 32'd0, 0, 0, 1'b0);
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; stall = 1'b0; op = 2'b00; alu_func = 4'd0;
        rd = 4'd0; rs = 4'd0; rt = 4'd0; imm = 32'd0;
        #12;
        check_eq("rst_bus_src", 32'(bus_src_sel), 32'd3);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_gp_en", 32'(gp_enable), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_imm_out", imm_out, 32'd0);
        @(negedge clock);
        clear = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_cmd(2'b10, 4'd0, i[3:0], 4'd0, 4'd0, 32'h100 + i, 0, 0, 1'b0);
            check_eq("ldi_done_lat", done_k, 32'd2);
            check_eq("ldi_gp_en", gp_val, 32'h1 << i);
            read_reg(i[3:0]);
            check_eq("ldi_readback", bus_at_gp, 32'h100 + i);
        end
        check_eq("mov_no_illegal", ill_cnt, 32'd0);

        run_cmd(2'b10, 4'd0, 4'd3, 4'd0, 4'd0, 32'd7, 0, 0, 1'b0);
        run_cmd(2'b10, 4'd0, 4'd4, 4'd0, 4'd0, 32'd5, 0, 0, 1'b0);
        run_cmd(2'b01, 4'd0, 4'd5, 4'd3, 4'd4, 32'd0, 0, 0, 1'b0);
        check_eq("alu_y_k", y_k, 32'd1);
        check_eq("alu_z_k", z_k, 32'd2);
        check_eq("alu_gp_k", gp_k, 32'd3);
        check_eq("alu_gp_en", gp_val, 32'h0020);
        check_eq("alu_done_k", done_k, 32'd4);
        check_eq("alu_enable_overlap", viol, 32'd0);
        read_reg(4'd5);
        check_eq("alu_add_result", bus_at_gp, 32'd12);

        run_cmd(2'b01, 4'd0, 4'd5, 4'd3, 4'd4, 32'd0, 2, 3, 1'b0);
        check_eq("stall_z_while_held", z_stalled, 32'd0);
        check_eq("stall_z_count", z_cnt, 32'd1);
        check_eq("stall_done_k", done_k, 32'd7);
        check_eq("stall_enable_overlap", viol, 32'd0);
        read_reg(4'd5);
        check_eq("stall_result", bus_at_gp, 32'd12);

        run_cmd(2'b01, 4'd1, 4'd6, 4'd3, 4'd4, 32'd0, 0, 0, 1'b0);
        read_reg(4'd6);
        check_eq("alu_sub_result", bus_at_gp, 32'd2);

        run_cmd(2'b11, 4'd0, 4'd7, 4'd0, 4'd0, 32'd0, 0, 0, 1'b1);
        check_eq("ill_done_k", done_k, 32'd1);
        check_eq("ill_pulse", ill_cnt, 32'd1);
        check_eq("ill_no_gp", gp_cnt, 32'd0);
        check_eq("ill_single_done", done_cnt, 32'd1);

        run_cmd(2'b01, 4'd0, 4'd5, 4'd3, 4'd4, 32'd0, 0, 0, 1'b1);
        check_eq("busy_start_single_done", done_cnt, 32'd1);
        check_eq("busy_start_no_illegal", ill_cnt, 32'd0);

        run_cmd(2'b10, 4'd0, 4'd2, 4'd0, 4'd0, 32'd9, 0, 0, 1'b0);
        run_cmd(2'b01, 4'd0, 4'd2, 4'd2, 4'd2, 32'd0, 0, 0, 1'b0);
        read_reg(4'd2);
        check_eq("alias_result", bus_at_gp, 32'd18);

        run_cmd(2'b10, 4'd0, 4'd6, 4'd0, 4'd0, 32'h55, 0, 0, 1'b0);
        @(negedge clock);
        op = 2'b01; alu_func = 4'd0; rd = 4'd6; rs = 4'd3; rt = 4'd4; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #2 clear = 1'b0;
        @(negedge clock);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_gp_en", 32'(gp_enable), 32'd0);
        check_eq("abort_yz_en", 32'({y_enable, z_enable}), 32'd0);
        check_eq("abort_bus_src", 32'(bus_src_sel), 32'd3);
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        read_reg(4'd6);
        check_eq("abort_rd_kept", bus_at_gp, 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Control sequencer for the mini SRC DataPath. It accepts one register-transfer command at a time and drives the DataPath control lines cycle by cycle: bus source select, GP register read select, GP register write enables, and Y/Z latch enables. Three command types are supported: register move, three-operand ALU op through Y/Z, and load-immediate. It sits between the instruction-level control (or testbench) and the DataPath.

Parameters:
DATA_WIDTH, 32, width of the immediate and bus data
NUM_REGS, 16, number of GP registers; width of gp_enable
SEL_WIDTH, 4, register index width; equals log2(NUM_REGS)

Ports:
clock  input  1  system clock; rising edge active
clear  input  1  asynchronous, active-low reset
start  input  1  command request; sampled only in IDLE
op  input  2  00=MOV rd<=rs, 01=ALU rd<=rs func rt, 10=LDI rd<=imm, 11=illegal
alu_func  input  4  ALU function code, passed through for ALU ops
rd  input  SEL_WIDTH  destination register
rs  input  SEL_WIDTH  source register A
rt  input  SEL_WIDTH  source register B
imm  input  DATA_WIDTH  immediate for LDI
stall  input  1  freeze sequencing in execute states
bus_src_sel  output  2  00=GP register, 01=Z, 10=immediate, 11=none
gp_register_select  output  SEL_WIDTH  GP register driven onto the bus when bus_src_sel=00
gp_enable  output  NUM_REGS  one-hot GP write enable
y_enable  output  1  latch bus into Y
z_enable  output  1  latch ALU result into Z
alu_func_out  output  4  ALU function to DataPath
imm_out  output  DATA_WIDTH  latched immediate
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
illegal  output  1  one-cycle pulse, coincident with done, for op=11

Behaviour:
- States: IDLE, MOV_T0, ALU_T0, ALU_T1, ALU_T2, LDI_T0, DONE.
- Reset (clear=0, async): state=IDLE. All latched fields are 0. Outputs: bus_src_sel=11, gp_register_select=0, gp_enable=0, y_enable=0, z_enable=0, alu_func_out=0, imm_out=0, busy=0, done=0, illegal=0. Reset mid-command aborts it with no further enables.
- All outputs are decoded from the state register and latched fields only; there is no combinational input-to-output path.
- IDLE: when start=1 at a clock edge, op/alu_func/rd/rs/rt/imm are latched and the state moves to MOV_T0, ALU_T0, LDI_T0, or DONE (op=11). start is ignored in all other states.
- MOV_T0: bus_src_sel=00, gp_register_select=rs, gp_enable=1<<rd. Next state DONE.
- ALU_T0: bus_src_sel=00, gp_register_select=rs, y_enable=1. Next state ALU_T1.
- ALU_T1: bus_src_sel=00, gp_register_select=rt, alu_func_out=func, z_enable=1. Next state ALU_T2.
- ALU_T2: bus_src_sel=01, gp_enable=1<<rd. Next state DONE.
- LDI_T0: bus_src_sel=10, imm_out=imm, gp_enable=1<<rd. Next state DONE.
- DONE: done=1 and illegal=(op==11). All enables are 0 and bus_src_sel=11. Next state IDLE unconditionally.
- Latency from the start-accept edge to the done cycle: MOV=2, LDI=2, ALU=4, illegal=1 cycles. The minimum spacing between accepted starts is the command length plus 1 (IDLE cycle).
- Stall: when stall=1 in any T state, the state holds, selects and alu_func_out hold, and gp_enable, y_enable, and z_enable are forced to 0. Execution resumes at the same T state when stall=0. Stall has no effect in IDLE or DONE.
- Enables: gp_enable is always one-hot or zero, and never asserts in the same cycle as y_enable or z_enable.
- Register aliasing: rd==rs and rd==rt are legal. Source values are captured in Y/Z before the write, so the result is correct.
- Changes to input fields after acceptance have no effect.

Test Plan:
- Reset: clear=0 mid-ALU_T1 -> next cycle busy=0, all enables 0, bus_src_sel=11. No register written; the previous value of rd persists on readback.
- LDI: for i=0..15, LDI rd=i imm=32'h100+i, then MOV to R0 and read back via gp_register_select=i -> BusMuxOut=32'h100+i. done pulses 2 cycles after each accept.
- ALU: R3=7, R4=5, ALU add rd=5 rs=3 rt=4 -> y_enable at accept+1, z_enable at accept+2, gp_enable=16'h0020 at accept+3, done at accept+4. R5 reads 12.
- Stall: stall=1 for 3 cycles during ALU_T1 -> z_enable=0 while stalled, then asserts once. done is delayed by exactly 3 cycles and the result is unchanged.
- Illegal/ignore: op=11 -> done=1 and illegal=1 at accept+1, gp_enable stays 0. A start pulsed while busy=1 produces no extra done.
- Aliasing: R2=9, ALU add rd=2 rs=2 rt=2 -> R2 reads 18.
